// File: rtl/udc_pkg.sv
// Shared types for the UDC configuration sequencer: FSM states, response
// status codes and counter register addresses.
package udc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_SETUP,
    RD_SAMPLE,
    START,
    ARM,
    RUN,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_RANGE  = 2'b01,
    ST_VERIFY = 2'b10,
    ST_TMO    = 2'b11
  } status_e;

  // Register index doubles as the bus address {a1,a0}
  localparam logic [1:0] ADDR_PLR = 2'b00;
  localparam logic [1:0] ADDR_ULR = 2'b01;
  localparam logic [1:0] ADDR_LLR = 2'b10;
  localparam logic [1:0] ADDR_CCR = 2'b11;

endpackage

// File: rtl/udc_bus_cycle.sv
// Bus strobe generator: decodes the sequencer phase into the 3-clock write
// and 2-clock read strobe pattern, and compares read-back data.
module udc_bus_cycle
  import udc_pkg::*;
(
  input  state_e     state,
  input  logic [1:0] addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  output logic       ncs,
  output logic       nrd,
  output logic       nwr,
  output logic       oe,
  output logic [1:0] bus_addr,
  output logic [7:0] bus_data,
  output logic       rd_match
);

  // Outputs depend only on the registered state, so an asynchronous reset of
  // the state releases the bus immediately.
  always_comb begin
    ncs      = 1'b1;
    nrd      = 1'b1;
    nwr      = 1'b1;
    oe       = 1'b0;
    bus_data = '0;
    unique case (state)
      WR_SETUP: begin
        ncs      = 1'b0;
        oe       = 1'b1;
        bus_data = wr_data;
      end
      WR_STROBE: begin
        ncs      = 1'b0;
        nwr      = 1'b0;
        oe       = 1'b1;
        bus_data = wr_data;
      end
      WR_HOLD: begin
        oe       = 1'b1;
        bus_data = wr_data;
      end
      RD_SETUP: begin
        ncs = 1'b0;
        nrd = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus_addr = addr;
  assign rd_match = (rd_data == wr_data);

endmodule

// File: rtl/udc_cfg_sequencer.sv
// Configuration sequencer for an up/down counter: writes PLR/ULR/LLR/CCR,
// optionally verifies them, starts the counter and reports the outcome.
module udc_cfg_sequencer
  import udc_pkg::*;
#(
  parameter int unsigned            TMO_W   = 16,
  parameter logic [TMO_W-1:0]       TMO_MAX = 16'hFFFF
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_plr_i,
  input  logic [7:0] cmd_ulr_i,
  input  logic [7:0] cmd_llr_i,
  input  logic [7:0] cmd_ccr_i,
  input  logic       cmd_verify_i,
  input  logic       abort_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [1:0] rsp_status_o,
  output logic [7:0] rsp_count_o,
  output logic       busy_o,
  output logic [7:0] udc_d_o,
  output logic       udc_d_oe_o,
  input  logic [7:0] udc_d_i,
  output logic       udc_ncs_o,
  output logic       udc_nrd_o,
  output logic       udc_nwr_o,
  output logic       udc_a0_o,
  output logic       udc_a1_o,
  output logic       udc_start_o,
  input  logic [7:0] udc_c_i,
  input  logic       udc_err_i,
  input  logic       udc_ec_i
);

  state_e           state, state_next;
  logic [1:0]       idx, idx_next;
  logic [3:0][7:0]  cfg;
  logic             verify_q;
  logic [TMO_W-1:0] tmo, tmo_inc;
  logic             ready_en;
  status_e          status_next;
  logic             rd_match;
  logic [1:0]       bus_addr;
  logic             cmd_take;

  udc_bus_cycle u_bus (
    .state    (state),
    .addr     (idx),
    .wr_data  (cfg[idx]),
    .rd_data  (udc_d_i),
    .ncs      (udc_ncs_o),
    .nrd      (udc_nrd_o),
    .nwr      (udc_nwr_o),
    .oe       (udc_d_oe_o),
    .bus_addr (bus_addr),
    .bus_data (udc_d_o),
    .rd_match (rd_match)
  );

  assign udc_a1_o    = bus_addr[1];
  assign udc_a0_o    = bus_addr[0];
  assign cmd_ready_o = (state == IDLE) && ready_en;
  assign cmd_take    = cmd_ready_o && cmd_valid_i;
  assign busy_o      = (state != IDLE);
  assign rsp_valid_o = (state == RESP);
  assign udc_start_o = (state == START);
  assign tmo_inc     = (tmo == '1) ? tmo : tmo + 1'b1;

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    status_next = ST_OK;
    unique case (state)
      IDLE:      if (cmd_take) begin
                   state_next = WR_SETUP;
                   idx_next   = '0;
                 end
      WR_SETUP:  state_next = WR_STROBE;
      WR_STROBE: state_next = WR_HOLD;
      WR_HOLD: begin
        if (idx == ADDR_CCR) begin
          idx_next   = '0;
          state_next = verify_q ? RD_SETUP : START;
        end else begin
          idx_next   = idx + 1'b1;
          state_next = WR_SETUP;
        end
      end
      RD_SETUP:  state_next = RD_SAMPLE;
      RD_SAMPLE: begin
        if (!rd_match) begin
          state_next  = RESP;
          status_next = ST_VERIFY;
        end else if (idx == ADDR_CCR) begin
          state_next = START;
        end else begin
          idx_next   = idx + 1'b1;
          state_next = RD_SETUP;
        end
      end
      START:     state_next = ARM;
      ARM: begin
        if (udc_err_i) begin
          state_next  = RESP;
          status_next = ST_RANGE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        // End-of-count takes priority over a coincident timeout
        if (udc_ec_i) begin
          state_next  = RESP;
          status_next = ST_OK;
        end else if (tmo_inc == TMO_MAX) begin
          state_next  = RESP;
          status_next = ST_TMO;
        end
      end
      RESP:      if (rsp_ready_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (abort_i && state != IDLE && state != RESP) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx          <= '0;
      cfg          <= '0;
      verify_q     <= 1'b0;
      tmo          <= '0;
      ready_en     <= 1'b0;
      rsp_status_o <= '0;
      rsp_count_o  <= '0;
    end else begin
      ready_en <= 1'b1;
      idx      <= idx_next;
      if (cmd_take) begin
        cfg      <= {cmd_ccr_i, cmd_llr_i, cmd_ulr_i, cmd_plr_i};
        verify_q <= cmd_verify_i;
      end
      if (state == ARM) begin
        tmo <= '0;
      end else if (state == RUN) begin
        tmo <= tmo_inc;
      end
      if (state_next == RESP && state != RESP) begin
        rsp_status_o <= status_next;
        rsp_count_o  <= udc_c_i;
      end
    end
  end

endmodule

// File: tb/tb_udc_cfg_sequencer.sv
// Directed bench for udc_cfg_sequencer: a per-cycle expected trace built from
// the transaction rules, plus literal checks on key scenario outcomes.
module tb_udc_cfg_sequencer;

  localparam int TMO = 32;

  logic       clock_i = 1'b0;
  logic       reset_ni;
  logic       cmd_valid_i, cmd_ready_o, cmd_verify_i, abort_i;
  logic [7:0] cmd_plr_i, cmd_ulr_i, cmd_llr_i, cmd_ccr_i;
  logic       rsp_valid_o, rsp_ready_i, busy_o;
  logic [1:0] rsp_status_o;
  logic [7:0] rsp_count_o;
  logic [7:0] udc_d_o, udc_d_i, udc_c_i;
  logic       udc_d_oe_o, udc_ncs_o, udc_nrd_o, udc_nwr_o, udc_a0_o, udc_a1_o;
  logic       udc_start_o, udc_err_i, udc_ec_i;

  always #5 clock_i = ~clock_i;

  udc_cfg_sequencer #(.TMO_W(16), .TMO_MAX(16'(TMO))) dut (
    .clock_i(clock_i), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_plr_i(cmd_plr_i), .cmd_ulr_i(cmd_ulr_i), .cmd_llr_i(cmd_llr_i), .cmd_ccr_i(cmd_ccr_i),
    .cmd_verify_i(cmd_verify_i), .abort_i(abort_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_status_o(rsp_status_o), .rsp_count_o(rsp_count_o), .busy_o(busy_o),
    .udc_d_o(udc_d_o), .udc_d_oe_o(udc_d_oe_o), .udc_d_i(udc_d_i),
    .udc_ncs_o(udc_ncs_o), .udc_nrd_o(udc_nrd_o), .udc_nwr_o(udc_nwr_o),
    .udc_a0_o(udc_a0_o), .udc_a1_o(udc_a1_o), .udc_start_o(udc_start_o),
    .udc_c_i(udc_c_i), .udc_err_i(udc_err_i), .udc_ec_i(udc_ec_i)
  );

  // Counter register file model; bad_idx selects a register that reads back 07
  logic [7:0] per_regs [4];
  int         bad_idx;
  always @(posedge clock_i)
    if (!udc_ncs_o && !udc_nwr_o) per_regs[{udc_a1_o, udc_a0_o}] <= udc_d_o;
  assign udc_d_i = (bad_idx == int'({udc_a1_o, udc_a0_o})) ? 8'h07 : per_regs[{udc_a1_o, udc_a0_o}];

  typedef struct {
    int         cyc;
    logic       ready, busy, rv, ncs, nrd, nwr, oe, start;
    logic [1:0] addr;
    logic [7:0] data;
    logic [1:0] status;
    logic [7:0] count;
  } exp_t;

  exp_t q[$];
  bit   cut, trace_on;
  int   abort_cyc, ec_cyc;
  int   checks, failures;
  int   start_cnt, rv_cnt, last_start_cyc;
  logic [1:0] seen_status;
  logic [7:0] seen_count;

  task automatic push_e(input logic ready, busy, rv, ncs, nrd, nwr, oe, start,
                        input logic [1:0] addr, input logic [7:0] data,
                        input logic [1:0] status, input logic [7:0] count);
    exp_t e;
    e.cyc = q.size(); e.ready = ready; e.busy = busy; e.rv = rv;
    e.ncs = ncs; e.nrd = nrd; e.nwr = nwr; e.oe = oe; e.start = start;
    e.addr = addr; e.data = data; e.status = status; e.count = count;
    q.push_back(e);
  endtask

  // One busy cycle; an abort seen in this cycle leaves the block idle next cycle
  task automatic bus(input logic ncs, nrd, nwr, oe, start, input logic [1:0] addr, input logic [7:0] data);
    if (cut) return;
    push_e(1'b0, 1'b1, 1'b0, ncs, nrd, nwr, oe, start, addr, data, 2'b00, 8'h00);
    if (q.size() - 1 == abort_cyc) begin
      push_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 8'h00);
      cut = 1;
    end
  endtask

  task automatic build(input logic [31:0] vals, input bit verify, input int bad, input bit err,
                       input int ec_delay, input int hold, input logic [7:0] c_base, input bit ramp);
    logic [7:0] v [4];
    logic [1:0] st;
    logic [7:0] cnt;
    bit         mism;
    int         t;
    for (int r = 0; r < 4; r++) v[r] = vals[31-8*r -: 8];
    q.delete(); cut = 0; ec_cyc = -1; mism = 0; st = 2'b00;
    push_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 8'h00);
    for (int r = 0; r < 4; r++) begin
      bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'(r), v[r]);
      bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'(r), v[r]);
      bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'(r), v[r]);
    end
    if (verify) begin
      for (int r = 0; r < 4 && !mism; r++) begin
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'(r), 8'h00);
        bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'(r), 8'h00);
        if (r == bad) begin mism = 1; st = 2'b10; end
      end
    end
    if (!mism) begin
      bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 8'h00);
      bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
      if (err) st = 2'b01;
      else begin
        for (int j = 0; j < TMO; j++) begin
          bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
          if (j == ec_delay) begin ec_cyc = q.size() - 1; st = 2'b00; break; end
          if (j == TMO - 1) st = 2'b11;
        end
      end
    end
    // Count is the counter value present in the last cycle before the response
    t = q.size() - 1;
    cnt = ramp ? c_base + 8'(t) : c_base;
    for (int k = 0; k <= hold; k++)
      if (!cut) push_e(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, st, cnt);
  endtask

  task automatic run(input logic [31:0] vals, input bit verify, input int bad, input bit err,
                     input int ec_delay, input int abort_at, input int hold,
                     input logic [7:0] c_base, input bit ramp);
    int  total;
    bit  has_resp;
    abort_cyc = abort_at;
    bad_idx   = bad;
    build(vals, verify, bad, err, ec_delay, hold, c_base, ramp);
    total    = q.size();
    has_resp = !cut;
    {cmd_plr_i, cmd_ulr_i, cmd_llr_i, cmd_ccr_i} = vals;
    cmd_verify_i = verify;
    udc_err_i    = err;
    for (int i = 0; i < total; i++) begin
      cmd_valid_i = (i == 0);
      udc_ec_i    = (i == ec_cyc);
      abort_i     = (i == abort_at);
      rsp_ready_i = has_resp && (i == total - 1);
      udc_c_i     = ramp ? c_base + 8'(i) : c_base;
      @(posedge clock_i); #1;
    end
    cmd_valid_i = 0; udc_ec_i = 0; abort_i = 0; rsp_ready_i = 0; udc_err_i = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  initial begin
    int s0, r0;
    checks = 0; failures = 0; trace_on = 0; start_cnt = 0; rv_cnt = 0; last_start_cyc = -1;
    seen_status = '0; seen_count = '0; bad_idx = -1; abort_cyc = -1; ec_cyc = -1;
    reset_ni = 0; cmd_valid_i = 0; cmd_verify_i = 0; abort_i = 0; rsp_ready_i = 0;
    cmd_plr_i = '0; cmd_ulr_i = '0; cmd_llr_i = '0; cmd_ccr_i = '0;
    udc_c_i = '0; udc_err_i = 0; udc_ec_i = 0;

    fork
      forever begin : cmp
        exp_t e;
        logic bad;
        @(negedge clock_i);
        if (trace_on && q.size() > 0) begin
          e = q.pop_front();
          bad = (cmd_ready_o !== e.ready) || (busy_o !== e.busy) || (rsp_valid_o !== e.rv) ||
                (udc_ncs_o !== e.ncs) || (udc_nrd_o !== e.nrd) || (udc_nwr_o !== e.nwr) ||
                (udc_d_oe_o !== e.oe) || (udc_start_o !== e.start);
          if (e.ncs == 1'b0) bad = bad || ({udc_a1_o, udc_a0_o} !== e.addr);
          if (e.oe) bad = bad || (udc_d_o !== e.data);
          if (e.rv) bad = bad || (rsp_status_o !== e.status) || (rsp_count_o !== e.count);
          checks++;
          if (bad) begin
            failures++;
            $display("FAIL trace cyc=%0d got rdy=%b bsy=%b rv=%b ncs=%b nrd=%b nwr=%b oe=%b st=%b a=%b d=%h s=%b c=%h expected rdy=%b bsy=%b rv=%b ncs=%b nrd=%b nwr=%b oe=%b st=%b a=%b d=%h s=%b c=%h",
                     e.cyc, cmd_ready_o, busy_o, rsp_valid_o, udc_ncs_o, udc_nrd_o, udc_nwr_o, udc_d_oe_o,
                     udc_start_o, {udc_a1_o, udc_a0_o}, udc_d_o, rsp_status_o, rsp_count_o,
                     e.ready, e.busy, e.rv, e.ncs, e.nrd, e.nwr, e.oe, e.start, e.addr, e.data, e.status, e.count);
          end
          if (udc_start_o) begin start_cnt++; last_start_cyc = e.cyc; end
          if (rsp_valid_o) begin rv_cnt++; seen_status = rsp_status_o; seen_count = rsp_count_o; end
        end
      end
    join_none

    #22;
    chk("reset_state", {4'h0, udc_ncs_o, udc_nrd_o, udc_nwr_o, udc_d_oe_o, udc_start_o, rsp_valid_o,
                        busy_o, cmd_ready_o, udc_d_o, udc_a1_o, udc_a0_o, rsp_status_o, rsp_count_o},
        {4'h0, 8'b1110_0000, 8'h00, 2'b00, 2'b00, 8'h00});
    @(posedge clock_i); #1;
    reset_ni = 1;
    #1 chk("ready_before_edge", 32'(cmd_ready_o), 32'd0);
    @(posedge clock_i); #1;
    chk("ready_first_edge", 32'({busy_o, cmd_ready_o}), 32'b01);
    trace_on = 1;

    // Plain configure and run, end-of-count after 3 run cycles
    s0 = start_cnt;
    run(32'h050A0201, 0, -1, 0, 3, -1, 0, 8'h40, 1);
    chk("a_start_cycle", last_start_cyc, 13);
    chk("a_start_once", start_cnt - s0, 1);
    chk("a_status", 32'(seen_status), 32'd0);
    chk("a_count", 32'(seen_count), 32'h52);
    chk("a_regs", {per_regs[0], per_regs[1], per_regs[2], per_regs[3]}, 32'h050A0201);

    // Verify with ULR reading back 07
    s0 = start_cnt;
    run(32'h050A0201, 1, 1, 0, -1, -1, 2, 8'h40, 1);
    chk("b_no_start", start_cnt - s0, 0);
    chk("b_status", 32'(seen_status), 32'd2);
    chk("b_count", 32'(seen_count), 32'h50);

    // Counter flags a range error in ARM
    run(32'h20100003, 0, -1, 1, -1, -1, 1, 8'h00, 0);
    chk("c_status", 32'(seen_status), 32'd1);
    chk("c_count", 32'(seen_count), 32'h00);

    // Verified config, no end-of-count: timeout, response held 10 cycles
    r0 = rv_cnt;
    run(32'h11223344, 1, -1, 0, -1, -1, 10, 8'h80, 1);
    chk("d_status", 32'(seen_status), 32'd3);
    chk("d_count", 32'(seen_count), 32'hB6);
    chk("d_resp_cycles", rv_cnt - r0, 11);

    // End-of-count in the same cycle the timeout would fire
    run(32'h01020304, 0, -1, 0, TMO - 1, -1, 0, 8'h00, 1);
    chk("e_status", 32'(seen_status), 32'd0);
    chk("e_count", 32'(seen_count), 32'h2E);

    // Abort during RUN
    r0 = rv_cnt;
    run(32'h0A0B0C0D, 0, -1, 0, -1, 17, 0, 8'h00, 1);
    chk("f_no_resp", rv_cnt - r0, 0);
    chk("f_idle", 32'({busy_o, cmd_ready_o}), 32'b01);

    // Abort during a write strobe
    r0 = rv_cnt; s0 = start_cnt;
    run(32'h0A0B0C0D, 0, -1, 0, -1, 2, 0, 8'h00, 1);
    chk("g_no_resp", rv_cnt - r0, 0);
    chk("g_no_start", start_cnt - s0, 0);

    // Reset pulsed during WR_STROBE releases the bus without a clock edge
    trace_on = 0;
    {cmd_plr_i, cmd_ulr_i, cmd_llr_i, cmd_ccr_i} = 32'h55667788;
    cmd_verify_i = 0;
    cmd_valid_i = 1;
    @(posedge clock_i); #1;
    cmd_valid_i = 0;
    @(posedge clock_i); #1;
    chk("h_in_strobe", 32'({udc_nwr_o, udc_d_oe_o, udc_ncs_o}), 32'b010);
    reset_ni = 0;
    #1 chk("h_async_release", 32'({udc_ncs_o, udc_nrd_o, udc_nwr_o, udc_d_oe_o, udc_start_o, busy_o, cmd_ready_o}),
           32'b1110000);
    @(posedge clock_i); #1;
    reset_ni = 1;
    chk("h_ready_low", 32'(cmd_ready_o), 32'd0);
    @(posedge clock_i); #1;
    chk("h_idle_after", 32'({busy_o, cmd_ready_o}), 32'b01);
    trace_on = 1;

    // Normal command after reset, end-of-count in the first run cycle
    run(32'h05060708, 0, -1, 0, 0, -1, 0, 8'h10, 1);
    chk("i_status", 32'(seen_status), 32'd0);
    chk("i_count", 32'(seen_count), 32'h1F);

    trace_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
